// File: rtl/axis_fifo.sv
// AXI4-Stream synchronous FIFO, first-word-fall-through, parametrised payload and depth.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward operation with oversize escape.
module axis_fifo #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned ALMOST_FULL_THR = DEPTH - 2
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic                         S_TVALID,
  output logic                         S_TREADY,
  input  logic [DATA_WIDTH-1:0]        S_TDATA,
  input  logic [USER_WIDTH-1:0]        S_TUSER,
  input  logic                         S_TLAST,
  output logic                         M_TVALID,
  input  logic                         M_TREADY,
  output logic [DATA_WIDTH-1:0]        M_TDATA,
  output logic [USER_WIDTH-1:0]        M_TUSER,
  output logic                         M_TLAST,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
`ifdef AXIS_FIFO_PACKET_MODE_EN
  ,
  output logic                         pkt_oversize
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = 1 + USER_WIDTH + DATA_WIDTH;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wptr, rptr, wptr_n, rptr_n;
  logic [CW-1:0] count_n;
  logic          wr_c, rd_c;
  logic          full_n, empty_n, m_tvalid_n;

  assign wr_c = S_TVALID & S_TREADY;
  assign rd_c = M_TVALID & M_TREADY;

  // Storage has no reset; entries are {TLAST, TUSER, TDATA}
  always_ff @(posedge ACLK) begin
    if (wr_c) mem[wptr[AW-1:0]] <= {S_TLAST, S_TUSER, S_TDATA};
  end

  assign head    = mem[rptr[AW-1:0]];
  assign M_TLAST = head[EW-1];
  assign M_TUSER = head[DATA_WIDTH +: USER_WIDTH];
  assign M_TDATA = head[DATA_WIDTH-1:0];

  always_comb begin
    wptr_n  = wptr + PW'(wr_c);
    rptr_n  = rptr + PW'(rd_c);
    count_n = count;
    if (wr_c && !rd_c)      count_n = count + CW'(1);
    else if (!wr_c && rd_c) count_n = count - CW'(1);
    full_n  = (wptr_n[AW-1:0] == rptr_n[AW-1:0]) && (wptr_n[AW] != rptr_n[AW]);
    empty_n = (wptr_n == rptr_n);
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [CW-1:0] pkt_cnt, pkt_cnt_n;
  logic          esc, esc_n;
  logic          pw_c, pr_c;

  assign pw_c = wr_c & S_TLAST;
  assign pr_c = rd_c & M_TLAST;

  // Full with no complete packet would deadlock; release cut-through until a TLAST leaves
  always_comb begin
    pkt_cnt_n = pkt_cnt;
    if (pw_c && !pr_c)      pkt_cnt_n = pkt_cnt + CW'(1);
    else if (pr_c && !pw_c) pkt_cnt_n = pkt_cnt - CW'(1);
    esc_n = esc;
    if (pr_c) esc_n = 1'b0;
    if (full_n && (pkt_cnt_n == '0)) esc_n = 1'b1;
    m_tvalid_n = !empty_n && ((pkt_cnt_n != '0) || esc_n);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pkt_cnt      <= '0;
      esc          <= 1'b0;
      pkt_oversize <= 1'b0;
    end else begin
      pkt_cnt <= pkt_cnt_n;
      esc     <= esc_n;
      if (esc_n) pkt_oversize <= 1'b1;
    end
  end
`else
  assign m_tvalid_n = !empty_n;
`endif

  // Flags are registered from next-state pointers so ready has no path from M_TREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      S_TREADY    <= 1'b0;
      M_TVALID    <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      count       <= count_n;
      S_TREADY    <= !full_n;
      M_TVALID    <= m_tvalid_n;
      almost_full <= (count_n >= CW'(ALMOST_FULL_THR));
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Directed self-checking bench for axis_fifo (DEPTH=16, 16-bit data, 1-bit user).
module tb_axis_fifo;

  logic        ACLK;
  logic        ARESETN;
  logic        S_TVALID;
  logic        S_TREADY;
  logic [15:0] S_TDATA;
  logic [0:0]  S_TUSER;
  logic        S_TLAST;
  logic        M_TVALID;
  logic        M_TREADY;
  logic [15:0] M_TDATA;
  logic [0:0]  M_TUSER;
  logic        M_TLAST;
  logic [4:0]  count;
  logic        almost_full;
`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic        pkt_oversize;
`endif

  int total = 0;
  int bad   = 0;

  axis_fifo #(
    .DATA_WIDTH(16), .USER_WIDTH(1), .DEPTH(16), .ALMOST_FULL_THR(14)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
    .S_TUSER(S_TUSER), .S_TLAST(S_TLAST),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
    .M_TUSER(M_TUSER), .M_TLAST(M_TLAST),
    .count(count), .almost_full(almost_full)
`ifdef AXIS_FIFO_PACKET_MODE_EN
    , .pkt_oversize(pkt_oversize)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int tx, rx, cyc;
    ARESETN = 1'b0; S_TVALID = 1'b0; S_TDATA = '0; S_TUSER = '0; S_TLAST = 1'b0;
    M_TREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_tready", 32'(S_TREADY), 0);
    chk("rst_tvalid", 32'(M_TVALID), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_af", 32'(almost_full), 0);

    // Release reset: ready rises one edge later
    ARESETN = 1'b1;
    #1 chk("rel_tready_pre", 32'(S_TREADY), 0);
    @(negedge ACLK);
    chk("rel_tready", 32'(S_TREADY), 1);
    chk("rel_tvalid", 32'(M_TVALID), 0);
    chk("rel_count", 32'(count), 0);

    // Single beat
    S_TVALID = 1'b1; S_TDATA = 16'hABCD; S_TUSER = 1'b1; S_TLAST = 1'b1;
    @(negedge ACLK);
    S_TVALID = 1'b0;
    chk("one_tvalid", 32'(M_TVALID), 1);
    chk("one_tdata", 32'(M_TDATA), 32'hABCD);
    chk("one_tuser", 32'(M_TUSER), 1);
    chk("one_tlast", 32'(M_TLAST), 1);
    chk("one_count", 32'(count), 1);
    M_TREADY = 1'b1;
    @(negedge ACLK);
    M_TREADY = 1'b0;
    chk("one_count_after", 32'(count), 0);
    chk("one_tvalid_after", 32'(M_TVALID), 0);

    // Fill to full with reads blocked
    for (int i = 0; i < 16; i++) begin
      S_TVALID = 1'b1; S_TDATA = 16'(i); S_TUSER = 1'(i & 1); S_TLAST = (i == 15);
      @(negedge ACLK);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 14));
      chk("fill_tready", 32'(S_TREADY), 32'(i < 15));
    end
    S_TDATA = 16'h0099; S_TLAST = 1'b0;
    @(negedge ACLK);
    chk("over_count", 32'(count), 16);
    chk("over_tready", 32'(S_TREADY), 0);
    S_TVALID = 1'b0;

    // Back-pressure: head stays put
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("bp_tvalid", 32'(M_TVALID), 1);
      chk("bp_tdata", 32'(M_TDATA), 0);
      chk("bp_tuser", 32'(M_TUSER), 0);
      chk("bp_tlast", 32'(M_TLAST), 0);
    end

    // Full with read and offered write: only the read happens
    M_TREADY = 1'b1; S_TVALID = 1'b1; S_TDATA = 16'h0077;
    @(negedge ACLK);
    S_TVALID = 1'b0;
    chk("fullrd_count", 32'(count), 15);
    chk("fullrd_tready", 32'(S_TREADY), 1);
    for (int j = 1; j < 16; j++) begin
      chk("drain_tdata", 32'(M_TDATA), 32'(j));
      chk("drain_tlast", 32'(M_TLAST), 32'(j == 15));
      @(negedge ACLK);
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_tvalid", 32'(M_TVALID), 0);

    // 40 beats across pointer wrap with random back-pressure
    tx = 0; rx = 0; cyc = 0;
    while (rx < 40 && cyc < 1000) begin
      chk("rnd_count_max", 32'(count <= 5'd16), 1);
      M_TREADY = 1'($urandom_range(0, 1));
      S_TVALID = (tx < 40);
      S_TDATA  = 16'(tx);
      S_TUSER  = 1'b0;
      S_TLAST  = ((tx % 4) == 3);
      if (M_TVALID && M_TREADY) begin
        chk("rnd_tdata", 32'(M_TDATA), 32'(rx));
        rx++;
      end
      if (S_TVALID && S_TREADY) tx++;
      @(negedge ACLK);
      cyc++;
    end
    S_TVALID = 1'b0; M_TREADY = 1'b0;
    chk("rnd_rx_total", 32'(rx), 40);
    chk("rnd_count_end", 32'(count), 0);
    chk("rnd_tvalid_end", 32'(M_TVALID), 0);

    // Reset in the middle of a transfer discards contents
    S_TLAST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      S_TVALID = 1'b1; S_TDATA = 16'(16'h0100 + i);
      @(negedge ACLK);
    end
    S_TVALID = 1'b1; S_TDATA = 16'h0103;
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_tvalid", 32'(M_TVALID), 0);
    chk("mid_rst_tready", 32'(S_TREADY), 0);
    S_TVALID = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("mid_rel_tready", 32'(S_TREADY), 1);
    chk("mid_rel_tvalid", 32'(M_TVALID), 0);
    S_TVALID = 1'b1; S_TDATA = 16'h5A5A; S_TLAST = 1'b1;
    @(negedge ACLK);
    S_TVALID = 1'b0; S_TLAST = 1'b0;
    chk("mid_new_tdata", 32'(M_TDATA), 32'h5A5A);
    chk("mid_new_count", 32'(count), 1);
    M_TREADY = 1'b1;
    @(negedge ACLK);
    M_TREADY = 1'b0;
    chk("mid_new_empty", 32'(M_TVALID), 0);

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // Store-and-forward: output held until TLAST is stored
    for (int i = 0; i < 4; i++) begin
      S_TVALID = 1'b1; S_TDATA = 16'(16'h0200 + i); S_TLAST = (i == 3);
      @(negedge ACLK);
      chk("pkt_tvalid", 32'(M_TVALID), 32'(i == 3));
    end
    S_TVALID = 1'b0; S_TLAST = 1'b0;
    chk("pkt_head", 32'(M_TDATA), 32'h0200);
    M_TREADY = 1'b1;
    repeat (4) @(negedge ACLK);
    M_TREADY = 1'b0;
    chk("pkt_drained", 32'(count), 0);
    chk("pkt_ovs_clear", 32'(pkt_oversize), 0);

    // Oversize packet: released once full without TLAST
    for (int i = 0; i < 16; i++) begin
      S_TVALID = 1'b1; S_TDATA = 16'(16'h0300 + i); S_TLAST = 1'b0;
      @(negedge ACLK);
      chk("ovs_tvalid", 32'(M_TVALID), 32'(i == 15));
      chk("ovs_flag", 32'(pkt_oversize), 32'(i == 15));
    end
    S_TVALID = 1'b0;
    chk("ovs_head", 32'(M_TDATA), 32'h0300);
    M_TREADY = 1'b1;
    @(negedge ACLK);
    M_TREADY = 1'b0;
    chk("ovs_count", 32'(count), 15);
    chk("ovs_still_valid", 32'(M_TVALID), 1);
    chk("ovs_sticky", 32'(pkt_oversize), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
Parametrised AXI4-Stream synchronous FIFO. It is the successor to the fixed 16-bit/1-bit stream payload definition: TDATA width, TUSER width and depth are all set per instance. It buffers one stream (TDATA/TUSER/TLAST) between a producer and a consumer in one clock domain, and reports occupancy and an almost-full flag. It sits between video/pixel producers and consumers wherever rate decoupling or back-pressure absorption is needed.

Parameters:
DATA_WIDTH, 16, TDATA width in bits (≥1).
USER_WIDTH, 1, TUSER width in bits (≥1).
DEPTH, 16, number of entries; power of two, ≥2.
ALMOST_FULL_THR, DEPTH-2, almost_full asserts when count ≥ this value (1..DEPTH).

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESETN  in  1  asynchronous, active-low reset.
S_TVALID  in  1  slave input valid.
S_TREADY  out  1  slave input ready.
S_TDATA  in  DATA_WIDTH  slave data.
S_TUSER  in  USER_WIDTH  slave user sideband.
S_TLAST  in  1  slave end of packet.
M_TVALID  out  1  master output valid.
M_TREADY  in  1  master output ready.
M_TDATA  out  DATA_WIDTH  master data.
M_TUSER  out  USER_WIDTH  master user sideband.
M_TLAST  out  1  master end of packet.
count  out  $clog2(DEPTH+1)  current number of stored entries.
almost_full  out  1  count ≥ ALMOST_FULL_THR.

Behaviour:
- Reset (ARESETN=0, asynchronous): pointers=0, count=0, M_TVALID=0, S_TREADY=0 while reset is asserted, almost_full=0. Storage contents are don't-care. S_TREADY rises on the first clock edge after reset deasserts.
- Reset during a transfer discards all stored data. No partial beat may appear after reset.
- Storage: DEPTH × (1+USER_WIDTH+DATA_WIDTH) array. Entry packing is {TLAST, TUSER, TDATA}, MSB to LSB.
- Write pointer and read pointer are each $clog2(DEPTH)+1 bits; the extra MSB handles wrap. Full = pointer addresses equal and MSBs differ. Empty = pointers equal.
- Write accept: S_TVALID & S_TREADY at an edge. S_TREADY = !full; it depends only on registered state, with no combinational path from M_TREADY.
- Read accept: M_TVALID & M_TREADY at an edge. M_TVALID = !empty, first-word-fall-through. M_TDATA/M_TUSER/M_TLAST hold the head entry and stay stable while M_TVALID=1 and M_TREADY=0.
- Latency: a beat written at edge N is visible on M_* with M_TVALID=1 after edge N. Minimum write-to-read latency is 1 cycle. There is no bypass when empty.
- count: +1 on write only, −1 on read only, unchanged on simultaneous write and read. It is registered and never exceeds DEPTH or goes below 0.
- When full with M_TREADY=1: the read occurs, S_TREADY stays 0 that cycle and goes to 1 the next cycle.
- When empty with S_TVALID=1: the write occurs and no read occurs that cycle.
- Pointers wrap modulo 2·DEPTH. Order is preserved across wrap.
- TLAST and TUSER pass through unaltered. The FIFO does not interpret them, except under the optional feature.

Optional Feature:
Macro AXIS_FIFO_PACKET_MODE_EN enables store-and-forward mode.

With the macro defined:
- A complete-packet counter (width $clog2(DEPTH+1)) increments on each accepted write with S_TLAST=1. It decrements on each accepted read with M_TLAST=1; simultaneous events leave it unchanged.
- M_TVALID = !empty & (pkt_cnt ≠ 0).
- Deadlock escape: if full and pkt_cnt=0, output is released in cut-through mode until the next TLAST is read.
- In the deadlock-escape case, a sticky output pkt_oversize (1 bit, reset 0) sets and remains set until reset.

Without the macro:
- Pure cut-through FIFO as described in Behaviour.
- pkt_oversize port is absent.

Test Plan:
- Reset then idle: after ARESETN rises → S_TREADY=1 one edge later, M_TVALID=0, count=0, almost_full=0.
- Single beat: write TDATA=16'hABCD, TUSER=1, TLAST=1 → next cycle M_TVALID=1 with the same values; count=1; after read, count=0 and M_TVALID=0.
- Fill with DEPTH=16 and M_TREADY=0: write 16 beats 0..15 → S_TREADY=0 after the 16th; almost_full=1 from count=14; count=16; a 17th S_TVALID is not accepted.
- Full plus simultaneous read/write, then drain across wrap: push 40 incrementing beats with M_TREADY toggling randomly → output sequence 0..39 in order with no loss or duplication; count never exceeds 16.
- Back-pressure stability: hold M_TREADY=0 for 5 cycles with M_TVALID=1 → M_TDATA/M_TUSER/M_TLAST unchanged all 5 cycles.
- Packet mode (macro defined): write a 4-beat packet with S_TLAST on beat 3 → M_TVALID=0 until beat 3 is accepted, then 1. Write a 20-beat packet with no TLAST into DEPTH=16 → at full, output releases and pkt_oversize=1.
